// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = $clog2(DW) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t        r_state, w_next;
  logic [DW-1:0] r_dvd, r_q, w_q_n;
  logic [VW-1:0] r_dvs, r_rem, w_rem_n;
  logic [CW-1:0] r_cnt;
  logic [VW:0]   w_p;
  logic          w_ge, w_last, w_zero;
  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  // The held remainder is always below the divisor, so only the trial value needs VW+1 bits.
  always_comb begin
    w_p     = {r_rem, r_dvd[DW-1]};
    w_ge    = w_p >= {1'b0, r_dvs};
    w_rem_n = w_ge ? VW'(w_p - {1'b0, r_dvs}) : w_p[VW-1:0];
    w_q_n   = {r_q[DW-2:0], w_ge};
    w_last  = r_cnt == CW'(DW - 1);
    w_zero  = divisor == '0;
    w_next  = (r_state == IDLE) ? (start ? (w_zero ? DONE : CALC) : IDLE) :
              (r_state == CALC) ? (w_last ? DONE : CALC) : IDLE;
    ready   = r_state == IDLE;
    done    = r_state == DONE;
  end
  // State, datapath and result registers; results change only when entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_dvd       <= dividend;
        r_dvs       <= divisor;
        r_rem       <= '0;
        r_q         <= '0;
        r_cnt       <= '0;
        div_by_zero <= w_zero;
        if (w_zero) begin
          quotient  <= '1;
          remainder <= dividend[VW-1:0];
        end
      end else if (r_state == CALC) begin
        r_dvd <= {r_dvd[DW-2:0], 1'b0};
        r_rem <= w_rem_n;
        r_q   <= w_q_n;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          quotient  <= w_q_n;
          remainder <= w_rem_n;
        end
      end
    end
  end
endmodule
